inv_add_round_key_sched: RTL

- Decryption-path AddRoundKey stage with its own key schedule.
- Sits directly downstream of InvSubBytes in the AES-128 inverse cipher and XORs each incoming 128-bit state with the correct round key.
- Expands the cipher key once into an 11-entry round-key store, then serves round keys in reverse order (10 down to 0), one per accepted state beat.
- Registered valid/ready on input and output.

---
 rtl/inv_add_round_key_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/inv_add_round_key_sched.sv
// AES-128 inverse-cipher AddRoundKey stage with on-chip key expansion, serving round keys 10..0.
// Optional key zeroization (key_clear port) is built when INV_ARK_KEY_ZEROIZE_EN is defined.

module SBox (
  input  logic [7:0] message,
  output logic [7:0] crypte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // NOTE: combinational logic uses blocking '=' so each line sees the values computed above it.
  always_comb begin
    // x^254 = x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
    sq  = message;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    crypte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module inv_add_round_key_sched #(
  parameter int NR  = 10,
  parameter int RKW = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_load,
  input  logic [0:RKW-1] key_in,
  output logic           key_ready,
  input  logic           state_valid,
  input  logic [0:RKW-1] state_in,
  output logic           state_ready,
  output logic           out_valid,
  output logic [0:RKW-1] out_data,
  input  logic           out_ready,
  output logic [3:0]     round_idx
`ifdef INV_ARK_KEY_ZEROIZE_EN
  ,
  input  logic           key_clear
`endif
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} fsm_t;
  localparam logic [3:0] LAST_IDX = 4'(NR);

  fsm_t           state;
  fsm_t           state_nxt;
  logic [3:0]     ctr;
  logic [0:RKW-1] store [0:NR];
  logic           clear;
  logic           load;
  logic           accept;
  logic [0:RKW-1] prev_rk;
  logic [0:31]    w0, w1, w2, w3;
  logic [0:31]    n0, n1, n2, n3;
  logic [0:31]    sub_rot;
  logic [7:0]     rcon;

`ifdef INV_ARK_KEY_ZEROIZE_EN
  assign clear = key_clear;
`else
  assign clear = 1'b0;
`endif

  // key_load beats a same-cycle accept; key_clear beats key_load
  assign load        = key_load && !clear;
  assign state_ready = key_ready && (!out_valid || out_ready) && !load && !clear;
  assign accept      = state_valid && state_ready;

  assign prev_rk = (ctr == 4'd0) ? store[0] : store[ctr - 4'd1];
  assign {w0, w1, w2, w3} = prev_rk;

  // SubWord(RotWord(w3)): byte 1 of w3 lands in byte 0 of the result
  SBox u_sbox0 (.message(w3[8:15]),  .crypte(sub_rot[0:7]));
  SBox u_sbox1 (.message(w3[16:23]), .crypte(sub_rot[8:15]));
  SBox u_sbox2 (.message(w3[24:31]), .crypte(sub_rot[16:23]));
  SBox u_sbox3 (.message(w3[0:7]),   .crypte(sub_rot[24:31]));

  always_comb begin
    rcon = 8'h00;
    case (ctr)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign n0 = w0 ^ sub_rot ^ {rcon, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // NOTE: next-state gets a default first so no path through the block leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = EXPAND;
      EXPAND:  if (!load && ctr == LAST_IDX) state_nxt = READY;
      READY:   if (load) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the key store is an array of flops, so clearing it on reset is legal and intended (no stale key survives).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) store[i] <= '0;
      ctr <= 4'd0;
    end else if (clear) begin
      for (int i = 0; i <= NR; i++) store[i] <= '0;
      ctr <= 4'd0;
    end else if (load) begin
      store[0] <= key_in;
      ctr      <= 4'd1;
    end else if (state == EXPAND) begin
      store[ctr] <= {n0, n1, n2, n3};
      ctr        <= ctr + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      round_idx <= LAST_IDX;
    end else if (clear) begin
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      round_idx <= LAST_IDX;
    end else begin
      key_ready <= (state == READY) && !load;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= state_in ^ store[round_idx];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (load)
        round_idx <= LAST_IDX;
      else if (accept)
        round_idx <= (round_idx == 4'd0) ? LAST_IDX : round_idx - 4'd1;
    end
  end
endmodule
